// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Committed-store buffer in front of the data memory's store port. Committed
// stores are queued in FIFO order and drained one at a time as a single-cycle
// store_req pulse. Between pulses the strobe is low for at least one cycle,
// because the memory latches a write on the rising edge of store_req. Loads
// can look into the buffer: an exact address match forwards the youngest
// pending value, and a partial overlap raises fwd_conflict so the load stalls.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   push_req           commit stage presents a store this cycle
//   push_address/value store being committed
//   full               DEPTH entries held (push ignored)
//   empty              no entries and drain idle
//   drain_hold         do not start a new drain this cycle
//   store_req          registered write strobe to data memory
//   store_address/value registered write address/data, valid with store_req
//   load_address       address of the load being issued
//   fwd_hit/fwd_value  youngest exact match and its data (0 when no hit)
//   fwd_conflict       some pending entry partially overlaps load_address
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int ADDRESS_SIZE = 32,
    parameter int OPERAND_SIZE = 32,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_req,
    input  logic [ADDRESS_SIZE-1:0] push_address,
    input  logic [OPERAND_SIZE-1:0] push_value,
    output logic                    full,
    output logic                    empty,
    input  logic                    drain_hold,
    output logic                    store_req,
    output logic [ADDRESS_SIZE-1:0] store_address,
    output logic [OPERAND_SIZE-1:0] store_value,
    input  logic [ADDRESS_SIZE-1:0] load_address,
    output logic                    fwd_hit,
    output logic [OPERAND_SIZE-1:0] fwd_value,
    output logic                    fwd_conflict
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
    localparam logic [ADDRESS_SIZE:0] NEAR_LIMIT = (ADDRESS_SIZE + 1)'(4);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    logic [ADDRESS_SIZE-1:0] addr_mem_r  [DEPTH];
    logic [OPERAND_SIZE-1:0] value_mem_r [DEPTH];
    logic [PW-1:0]           head_r;
    logic [PW-1:0]           tail_r;
    logic [CW-1:0]           count_r;
    state_t                  state_r;
    logic                    store_req_r;
    logic [ADDRESS_SIZE-1:0] store_address_r;
    logic [OPERAND_SIZE-1:0] store_value_r;

    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    fwd_hit_s;
    logic [OPERAND_SIZE-1:0] fwd_value_s;
    logic                    fwd_conflict_s;
    logic [PW-1:0]           idx_s;
    logic                    valid_s;
    logic [ADDRESS_SIZE:0]   diff_s;

    // full comes from the registered count only, so a pop in the same cycle
    // does not make room for a push; the producer holds the store instead.
    assign full_s = (count_r == FULL_COUNT);
    assign push_s = push_req & ~full_s;
    // The head is popped on the WRITE->IDLE edge.
    assign pop_s  = (state_r == WRITE);

    // Entry storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i]  <= '0;
                value_mem_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                addr_mem_r[tail_r]  <= push_address;
                value_mem_r[tail_r] <= push_value;
                tail_r              <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Drain FSM: IDLE launches a write from the head, WRITE always returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            store_req_r     <= 1'b0;
            store_address_r <= '0;
            store_value_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if ((count_r != CW'(0)) && !drain_hold) begin
                        state_r         <= WRITE;
                        store_req_r     <= 1'b1;
                        store_address_r <= addr_mem_r[head_r];
                        store_value_r   <= value_mem_r[head_r];
                    end else begin
                        state_r     <= IDLE;
                        store_req_r <= 1'b0;
                    end
                end
                WRITE: begin
                    state_r     <= IDLE;
                    store_req_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    store_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding search from oldest to youngest so the youngest exact match
    // wins. Distance is taken at ADDRESS_SIZE+1 bits so it never wraps.
    always_comb begin
        fwd_hit_s      = 1'b0;
        fwd_value_s    = '0;
        fwd_conflict_s = 1'b0;
        idx_s          = '0;
        valid_s        = 1'b0;
        diff_s         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s   = head_r + PW'(k);
            valid_s = (CW'(k) < count_r);
            diff_s  = ({1'b0, addr_mem_r[idx_s]} >= {1'b0, load_address}) ?
                      ({1'b0, addr_mem_r[idx_s]} - {1'b0, load_address}) :
                      ({1'b0, load_address} - {1'b0, addr_mem_r[idx_s]});
            fwd_hit_s      = fwd_hit_s | (valid_s & (diff_s == '0));
            fwd_value_s    = (valid_s && (diff_s == '0)) ? value_mem_r[idx_s] : fwd_value_s;
            fwd_conflict_s = fwd_conflict_s |
                             (valid_s & (diff_s != '0) & (diff_s < NEAR_LIMIT));
        end
    end

    assign full          = full_s;
    assign empty         = (count_r == CW'(0)) && (state_r == IDLE);
    assign store_req     = store_req_r;
    assign store_address = store_address_r;
    assign store_value   = store_value_r;
    assign fwd_hit       = fwd_hit_s;
    assign fwd_value     = fwd_value_s;
    assign fwd_conflict  = fwd_conflict_s;

endmodule

// File: doc/store_buffer.md
# store_buffer

Committed-store buffer sitting directly upstream of the data memory's store port. Holds up to DEPTH committed stores in FIFO order and drains them one at a time as a store_req pulse, since the memory latches a write on the rising edge of store_req. It also provides store-to-load forwarding, so loads see pending stores, and flags partially overlapping loads for stall.

## Interface
- ADDRESS_SIZE, 32, byte address width
- OPERAND_SIZE, 32, store data width (one word, 4 bytes)
- DEPTH, 4, entry count; power of two, ≥2
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- push_req  input  1  commit stage presents a store this cycle
- push_address  input  ADDRESS_SIZE  store byte address
- push_value  input  OPERAND_SIZE  store data
- full  output  1  buffer holds DEPTH entries; push ignored
- empty  output  1  buffer holds 0 entries and drain FSM is IDLE
- drain_hold  input  1  suppress starting a new drain (e.g. memory busy)
- store_req  output  1  registered write strobe to data memory
- store_address  output  ADDRESS_SIZE  registered, valid while store_req
- store_value  output  OPERAND_SIZE  registered, valid while store_req
- load_address  input  ADDRESS_SIZE  address of the load being issued
- fwd_hit  output  1  youngest matching entry has an exact address match
- fwd_value  output  OPERAND_SIZE  data of that entry; 0 when !fwd_hit
- fwd_conflict  output  1  some entry partially overlaps load_address

## Operation
- Storage: DEPTH entries {address, value} in a circular array; head and tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Push: on an edge with push_req && !full, write the entry at tail, tail+1, count+1. full is derived from the registered count only. A push in the same cycle as a pop while full is refused, and the producer must hold it.
- Drain FSM, two states:
  - IDLE: store_req=0. Go to WRITE when count>0 && !drain_hold. Load store_address/store_value from the head entry.
  - WRITE: store_req=1. Always go to IDLE. Pop the head (head+1, count−1).
  - Result: store_req is a one-cycle pulse separated by at least one low cycle, giving max 1 store per 2 cycles.
- drain_hold only blocks the IDLE→WRITE transition; it never truncates a WRITE in progress.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Forwarding (combinational on load_address): compare against every valid entry, including the head while in WRITE, since it is popped only at WRITE→IDLE.
  - exact: entry.address == load_address.
  - overlap: |entry.address − load_address| < 4 and not exact, computed at ADDRESS_SIZE+1 bits, no wrap.
  - fwd_hit/fwd_value come from the youngest exact-matching entry, i.e. nearest tail.
  - fwd_conflict=1 if any valid entry overlaps, regardless of fwd_hit.
  - The consumer stalls the load while fwd_conflict=1.
- Pushes in the current cycle are not visible to forwarding until after the edge.

## Timing
- Reset values:
  - full=0, empty=1, store_req=0, store_address=0, store_value=0
  - fwd_hit=0, fwd_value=0, fwd_conflict=0
  - head=tail=count=0, FSM=IDLE
- Reset mid-WRITE: store_req drops asynchronously, and all pending entries are discarded.
- Push at edge t into an empty buffer: count=1 after t; IDLE→WRITE at edge t+1; store_req high from t+1 to t+2; entry popped at t+2.
- Back-to-back drain: store_req is high in cycles t+1, t+3, t+5…, low in between.
- empty rises on the edge that pops the last entry, provided no push occurs at the same edge.
- Pointer wrap: after DEPTH pushes and pops, pointers return to 0. No behavioural discontinuity is permitted.

## Test plan
- Reset check: after reset, empty=1, full=0, store_req=0. Push A=0x10/0xDEADBEEF → store_req high exactly one cycle at edge+1, store_address=0x10, store_value=0xDEADBEEF; then empty=1.
- Fill: DEPTH=4 pushes in 4 consecutive cycles with drain_hold=1 → full=1. A 5th push is ignored. Release drain_hold → 4 pulses in alternating cycles, in push order.
- Forwarding: push 0x20/0x1, then 0x20/0x2. load_address=0x20 → fwd_hit=1, fwd_value=0x2. load_address=0x22 → fwd_conflict=1, fwd_hit=0. load_address=0x24 → all 0.
- Simultaneous push and pop at count=2 → count stays 2; next two pulses carry the correct FIFO data.
- Wrap: 10 stores streamed with a push every 2 cycles → all 10 addresses and values appear on the store port in order, and the buffer is never full.
- Reset asserted during WRITE with 3 entries → store_req=0 immediately, empty=1. No further pulses after reset release.
